// File: rtl/llc_input_arbiter_pkg.sv
// Shared types for the LLC input arbiter: grant encodings, channel indices and
// the default set-counter width.
package llc_input_arbiter_pkg;

  localparam int LLC_SET_BITS = 10;

  typedef enum logic [2:0] {
    GRANT_NONE    = 3'd0,
    GRANT_RSP     = 3'd1,
    GRANT_RST_TB  = 3'd2,
    GRANT_WALK    = 3'd3,
    GRANT_STALLED = 3'd4,
    GRANT_REQ     = 3'd5,
    GRANT_DMA     = 3'd6
  } llc_grant_t;

  // Eligibility/winner bit i corresponds to grant code i+1.
  localparam int NUM_CH     = 6;
  localparam int CH_RSP     = 0;
  localparam int CH_RST_TB  = 1;
  localparam int CH_WALK    = 2;
  localparam int CH_STALLED = 3;
  localparam int CH_REQ     = 4;
  localparam int CH_DMA     = 5;

  function automatic llc_grant_t onehot_to_grant(input logic [NUM_CH-1:0] win);
    llc_grant_t g;
    g = GRANT_NONE;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win[i]) g = llc_grant_t'(3'(i + 1));
    end
    return g;
  endfunction

endpackage

// File: rtl/llc_input_arbiter_if.sv
// Channel valid/ready pairs, pass control and grant/walk status of the LLC
// input arbiter. The arbiter uses the slave modport.
interface llc_input_arbiter_if #(
  parameter int SET_BITS = llc_input_arbiter_pkg::LLC_SET_BITS
);
  import llc_input_arbiter_pkg::*;

  logic                llc_rsp_in_valid;
  logic                llc_rst_tb_valid;
  logic                llc_req_in_valid;
  logic                llc_dma_req_in_valid;
  logic                llc_rst_tb_i;
  logic                req_in_stalled_valid;
  logic                req_stall;
  logic                core_done;
  logic                llc_rsp_in_ready;
  logic                llc_rst_tb_ready;
  logic                llc_req_in_ready;
  logic                llc_dma_req_in_ready;
  llc_grant_t          grant;
  logic                grant_valid;
  logic [SET_BITS-1:0] walk_set;
  logic                walk_is_rst;
  logic                walk_active;
  logic                llc_rst_tb_done_valid;
  logic                llc_rst_tb_done_ready;

  modport master (
    output llc_rsp_in_valid, llc_rst_tb_valid, llc_req_in_valid, llc_dma_req_in_valid,
    output llc_rst_tb_i, req_in_stalled_valid, req_stall, core_done, llc_rst_tb_done_ready,
    input  llc_rsp_in_ready, llc_rst_tb_ready, llc_req_in_ready, llc_dma_req_in_ready,
    input  grant, grant_valid, walk_set, walk_is_rst, walk_active, llc_rst_tb_done_valid
  );

  modport slave (
    input  llc_rsp_in_valid, llc_rst_tb_valid, llc_req_in_valid, llc_dma_req_in_valid,
    input  llc_rst_tb_i, req_in_stalled_valid, req_stall, core_done, llc_rst_tb_done_ready,
    output llc_rsp_in_ready, llc_rst_tb_ready, llc_req_in_ready, llc_dma_req_in_ready,
    output grant, grant_valid, walk_set, walk_is_rst, walk_active, llc_rst_tb_done_valid
  );

endinterface

// File: rtl/llc_arb_prio_sel.sv
// Combinational priority selector: one-hot winner from the eligibility vector.
// prefer_dma lets DMA outrank REQ (starvation override or round-robin turn).
module llc_arb_prio_sel
  import llc_input_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] elig,
  input  logic              prefer_dma,
  output logic [NUM_CH-1:0] win
);

  always_comb begin
    win = '0;
    if (elig[CH_RSP])                      win[CH_RSP]     = 1'b1;
    else if (elig[CH_RST_TB])              win[CH_RST_TB]  = 1'b1;
    else if (elig[CH_WALK])                win[CH_WALK]    = 1'b1;
    else if (elig[CH_STALLED])             win[CH_STALLED] = 1'b1;
    else if (prefer_dma && elig[CH_DMA])   win[CH_DMA]     = 1'b1;
    else if (elig[CH_REQ])                 win[CH_REQ]     = 1'b1;
    else if (elig[CH_DMA])                 win[CH_DMA]     = 1'b1;
  end

endmodule

// File: rtl/llc_input_arbiter.sv
// LLC input arbiter: picks one channel per DECODE->UPDATE pass, runs the
// flush/reset set walk and guards DMA from starvation. LLC_ARB_RR_EN selects
// round-robin REQ/DMA sharing instead of fixed REQ > DMA with starvation override.
module llc_input_arbiter
  import llc_input_arbiter_pkg::*;
#(
  parameter int SET_BITS   = LLC_SET_BITS,
  parameter int STARVE_MAX = 7
)(
  input logic               clk,
  input logic               rst,
  llc_input_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_nxt;
  llc_grant_t          grant;
  logic [SET_BITS-1:0] walk_set;
  logic                walk_active, walk_is_rst;
  logic [NUM_CH-1:0]   elig, win;
  logic                prefer_dma, arb_en, last_set;
  logic                grant_valid, done_valid;

  // Readies are gated by reset so they drop the instant reset is asserted.
  assign arb_en   = (state == IDLE) && rst;
  assign last_set = (walk_set == '1);

  always_comb begin
    elig             = '0;
    elig[CH_RSP]     = bus.llc_rsp_in_valid;
    elig[CH_RST_TB]  = bus.llc_rst_tb_valid && !walk_active;
    elig[CH_WALK]    = walk_active;
    elig[CH_STALLED] = bus.req_in_stalled_valid && !bus.req_stall;
    elig[CH_REQ]     = bus.llc_req_in_valid && !bus.req_stall && !walk_active;
    elig[CH_DMA]     = bus.llc_dma_req_in_valid && !bus.req_stall && !walk_active;
  end

  llc_arb_prio_sel u_prio_sel (
    .elig       (elig),
    .prefer_dma (prefer_dma),
    .win        (win)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_valid = 1'b0;
    done_valid  = 1'b0;
    unique case (state)
      IDLE: if (arb_en && (|win)) state_nxt = BUSY;
      BUSY: begin
        grant_valid = 1'b1;
        if (bus.core_done)
          state_nxt = (grant == GRANT_WALK && last_set) ? DONE : IDLE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (bus.llc_rst_tb_done_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant register and set walk; grant reads NONE outside BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant       <= GRANT_NONE;
      walk_set    <= '0;
      walk_active <= 1'b0;
      walk_is_rst <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          grant <= onehot_to_grant(win);
          if (win[CH_RST_TB]) begin
            walk_active <= 1'b1;
            walk_is_rst <= bus.llc_rst_tb_i;
            walk_set    <= '0;
          end
        end
        BUSY: if (bus.core_done) begin
          grant <= GRANT_NONE;
          if (grant == GRANT_RST_TB || grant == GRANT_WALK)
            walk_set <= walk_set + SET_BITS'(1);
        end
        DONE: if (bus.llc_rst_tb_done_ready) walk_active <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef LLC_ARB_RR_EN
  logic rr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     rr_ptr <= 1'b0;
    else if (arb_en && (win[CH_REQ] || win[CH_DMA])) rr_ptr <= ~rr_ptr;
  end

  assign prefer_dma = rr_ptr;
`else
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] starve_cnt;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'h7) ? v : v + 3'd1;
  endfunction

  // Count REQ wins that left an eligible DMA waiting; any DMA win clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      starve_cnt <= '0;
    else if (arb_en && win[CH_DMA])                starve_cnt <= '0;
    else if (arb_en && win[CH_REQ] && elig[CH_DMA]) starve_cnt <= sat_inc3(starve_cnt);
  end

  assign prefer_dma = (starve_cnt >= STARVE_LIM);
`endif

  assign bus.llc_rsp_in_ready      = arb_en && win[CH_RSP];
  assign bus.llc_rst_tb_ready      = arb_en && win[CH_RST_TB];
  assign bus.llc_req_in_ready      = arb_en && win[CH_REQ];
  assign bus.llc_dma_req_in_ready  = arb_en && win[CH_DMA];
  assign bus.grant                 = grant;
  assign bus.grant_valid           = grant_valid;
  assign bus.walk_set              = walk_set;
  assign bus.walk_is_rst           = walk_is_rst;
  assign bus.walk_active           = walk_active;
  assign bus.llc_rst_tb_done_valid = done_valid;

endmodule

// File: tb/tb_llc_input_arbiter.sv
// Bench for llc_input_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a pass-level behavioural model.
module tb_llc_input_arbiter;
  import llc_input_arbiter_pkg::*;

  localparam int SB   = 2;
  localparam int SMAX = 7;
  localparam int LAST = (1 << SB) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  llc_input_arbiter_if #(.SET_BITS(SB)) bus();

  llc_input_arbiter #(.SET_BITS(SB), .STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic s_rsp, s_rst_tb, s_rst_i, s_req, s_dma, s_stalled, s_stall, s_done, s_dready;

  // Model: grant being served (0 = none), pending done, walk bookkeeping.
  int m_grant, m_set, m_starve;
  bit m_done_pend, m_walk, m_is_rst, m_rr;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  function automatic void model_reset();
    m_grant = 0; m_set = 0; m_starve = 0;
    m_done_pend = 1'b0; m_walk = 1'b0; m_is_rst = 1'b0; m_rr = 1'b0;
  endfunction

  function automatic void clear_stim();
    s_rsp = 0; s_rst_tb = 0; s_rst_i = 0; s_req = 0; s_dma = 0;
    s_stalled = 0; s_stall = 0; s_done = 0; s_dready = 0;
  endfunction

  task automatic drive();
    bus.llc_rsp_in_valid      = s_rsp;
    bus.llc_rst_tb_valid      = s_rst_tb;
    bus.llc_rst_tb_i          = s_rst_i;
    bus.llc_req_in_valid      = s_req;
    bus.llc_dma_req_in_valid  = s_dma;
    bus.req_in_stalled_valid  = s_stalled;
    bus.req_stall             = s_stall;
    bus.core_done             = s_done;
    bus.llc_rst_tb_done_ready = s_dready;
  endtask

  // Winner by the priority list, as a grant code.
  function automatic int model_pick();
    bit req_ok, dma_ok;
    req_ok = s_req && !s_stall && !m_walk;
    dma_ok = s_dma && !s_stall && !m_walk;
    if (s_rsp) return 1;
    if (s_rst_tb && !m_walk) return 2;
    if (m_walk) return 3;
    if (s_stalled && !s_stall) return 4;
`ifdef LLC_ARB_RR_EN
    if (req_ok && dma_ok) return m_rr ? 6 : 5;
`else
    if (dma_ok && m_starve >= SMAX) return 6;
`endif
    if (req_ok) return 5;
    if (dma_ok) return 6;
    return 0;
  endfunction

  task automatic compare_and_update();
    int pick, er;
    bit idle, dma_ok;
    pick   = model_pick();
    idle   = (m_grant == 0) && !m_done_pend;
    er     = idle ? pick : 0;
    dma_ok = s_dma && !s_stall && !m_walk;
    chk("grant",        int'(bus.grant),                 m_grant);
    chk("grant_valid",  int'(bus.grant_valid),           int'(m_grant != 0));
    chk("rsp_ready",    int'(bus.llc_rsp_in_ready),      int'(er == 1));
    chk("rst_tb_ready", int'(bus.llc_rst_tb_ready),      int'(er == 2));
    chk("req_ready",    int'(bus.llc_req_in_ready),      int'(er == 5));
    chk("dma_ready",    int'(bus.llc_dma_req_in_ready),  int'(er == 6));
    chk("done_valid",   int'(bus.llc_rst_tb_done_valid), int'(m_done_pend));
    chk("walk_set",     int'(bus.walk_set),              m_set);
    chk("walk_active",  int'(bus.walk_active),           int'(m_walk));
    chk("walk_is_rst",  int'(bus.walk_is_rst),           int'(m_is_rst));
    if (idle) begin
      if (pick == 2) begin m_walk = 1'b1; m_is_rst = s_rst_i; m_set = 0; end
      if (pick == 5 || pick == 6) m_rr = !m_rr;
      if (pick == 6) m_starve = 0;
      else if (pick == 5 && dma_ok && m_starve < 7) m_starve++;
      m_grant = pick;
    end else if (m_grant != 0) begin
      if (s_done) begin
        if (m_grant == 3 && m_set == LAST) begin m_set = 0; m_done_pend = 1'b1; end
        else if (m_grant == 2 || m_grant == 3) m_set++;
        m_grant = 0;
      end
    end else if (s_dready) begin
      m_done_pend = 1'b0; m_walk = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    compare_and_update();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_stim(); drive(); model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ng, nw, nreq, found;
    int gl[16];
    int wg[8];
    int ws[8];
    int exp;
    gl = '{default: 0}; wg = '{default: 0}; ws = '{default: 0};

    rst = 1'b0;
    clear_stim(); drive(); model_reset();
    repeat (2) @(negedge clk);
    chk("reset_grant",      int'(bus.grant), 0);
    chk("reset_gvalid",     int'(bus.grant_valid), 0);
    chk("reset_walk_set",   int'(bus.walk_set), 0);
    chk("reset_walk_act",   int'(bus.walk_active), 0);
    chk("reset_done_valid", int'(bus.llc_rst_tb_done_valid), 0);
    @(posedge clk); #1 rst = 1'b1;

    // RSP beats REQ and DMA; REQ follows once the RSP pass completes.
    s_rsp = 1; s_req = 1; s_dma = 1; step();
    chk("t1_rsp_ready", int'(bus.llc_rsp_in_ready), 1);
    chk("t1_req_ready", int'(bus.llc_req_in_ready), 0);
    chk("t1_dma_ready", int'(bus.llc_dma_req_in_ready), 0);
    s_rsp = 0; s_done = 1; step();
    chk("t1_grant_rsp", int'(bus.grant), 1);
    s_done = 0; step();
    chk("t1_req_ready_next", int'(bus.llc_req_in_ready), 1);
    s_done = 1; step();
    chk("t1_grant_req", int'(bus.grant), 5);
    clear_stim(); step();

    // Stall blocks REQ, DMA and stalled resume; STALLED wins when it drops.
    do_reset();
    s_stall = 1; s_req = 1; s_dma = 1; s_stalled = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_grant", int'(bus.grant_valid), 0);
      chk("stall_no_req_ready", int'(bus.llc_req_in_ready), 0);
    end
    s_stall = 0; step();
    s_stalled = 0; s_done = 1; step();
    chk("stall_grant_stalled", int'(bus.grant), 4);
    clear_stim(); step();

    // REQ and DMA continuously valid: starvation override or round-robin.
    do_reset();
    s_req = 1; s_dma = 1; s_done = 1;
    ng = 0;
    for (int i = 0; i < 40 && ng < 16; i++) begin
      step();
      if (bus.grant_valid) begin gl[ng] = int'(bus.grant); ng++; end
    end
    chk("arb_grant_count", ng, 16);
    for (int i = 0; i < 16; i++) begin
`ifdef LLC_ARB_RR_EN
      exp = (i % 2 == 0) ? 5 : 6;
`else
      exp = (i % 8 == 7) ? 6 : 5;
`endif
      chk($sformatf("arb_seq_%0d", i), gl[i], exp);
    end

    // Flush walk over 4 sets with REQ pending throughout.
    do_reset();
    s_rst_tb = 1; s_rst_i = 0; step();
    chk("walk_rst_tb_ready", int'(bus.llc_rst_tb_ready), 1);
    s_rst_tb = 0; s_req = 1; s_done = 1;
    nw = 0; nreq = 0;
    for (int i = 0; i < 30 && !bus.llc_rst_tb_done_valid; i++) begin
      step();
      if (bus.grant_valid && nw < 8) begin
        wg[nw] = int'(bus.grant); ws[nw] = int'(bus.walk_set); nw++;
      end
      if (bus.llc_req_in_ready || bus.grant == GRANT_REQ) nreq++;
    end
    chk("walk_pass_count", nw, 4);
    chk("walk_g0", wg[0], 2); chk("walk_s0", ws[0], 0);
    chk("walk_g1", wg[1], 3); chk("walk_s1", ws[1], 1);
    chk("walk_g2", wg[2], 3); chk("walk_s2", ws[2], 2);
    chk("walk_g3", wg[3], 3); chk("walk_s3", ws[3], 3);
    chk("walk_no_req", nreq, 0);
    chk("walk_set_wrapped", int'(bus.walk_set), 0);
    s_done = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("walk_done_held", int'(bus.llc_rst_tb_done_valid), 1);
    end
    s_dready = 1; step();
    s_dready = 0; step();
    chk("walk_cleared", int'(bus.walk_active), 0);
    chk("walk_req_after", int'(bus.llc_req_in_ready), 1);

    // Reset walk aborted by reset while serving set 2.
    do_reset();
    s_rst_tb = 1; s_rst_i = 1; step();
    s_rst_tb = 0; s_done = 1; s_req = 1; s_dma = 1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (bus.grant == GRANT_WALK && bus.walk_set == 2'd2) found = 1;
    end
    chk("abort_reached_set2", found, 1);
    chk("abort_walk_is_rst", int'(bus.walk_is_rst), 1);
    rst = 1'b0;
    #1;
    chk("abort_grant",      int'(bus.grant), 0);
    chk("abort_gvalid",     int'(bus.grant_valid), 0);
    chk("abort_req_ready",  int'(bus.llc_req_in_ready), 0);
    chk("abort_dma_ready",  int'(bus.llc_dma_req_in_ready), 0);
    chk("abort_walk_set",   int'(bus.walk_set), 0);
    chk("abort_walk_act",   int'(bus.walk_active), 0);
    chk("abort_walk_rst",   int'(bus.walk_is_rst), 0);
    chk("abort_done_valid", int'(bus.llc_rst_tb_done_valid), 0);
    clear_stim(); drive(); model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();
    chk("abort_post_grant", int'(bus.grant), 0);
    step();
    chk("abort_post_gvalid", int'(bus.grant_valid), 0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s_rsp     = ($urandom_range(0, 3) == 0);
      s_rst_tb  = ($urandom_range(0, 24) == 0);
      s_rst_i   = 1'($urandom_range(0, 1));
      s_req     = 1'($urandom_range(0, 1));
      s_dma     = 1'($urandom_range(0, 1));
      s_stalled = ($urandom_range(0, 4) == 0);
      s_stall   = ($urandom_range(0, 4) == 0);
      s_done    = ($urandom_range(0, 2) == 0);
      s_dready  = 1'($urandom_range(0, 1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
